// File: rtl/core_msg_pkg.sv
// Shared constants and helpers for the core message arbiter.
package core_msg_pkg;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DROP_CNT_W     = 32;

  function automatic int core_id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/core_msg_arbiter_if.sv
// Merged message port toward the host/scheduler: valid/ready with source core id.
interface core_msg_arbiter_if
  import core_msg_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int CORE_ID_WIDTH = 2
);
  logic [DATA_WIDTH-1:0]    m_msg_data;
  logic [CORE_ID_WIDTH-1:0] m_msg_core_id;
  logic                     m_msg_valid;
  logic                     m_msg_ready;

  modport master (output m_msg_data, m_msg_core_id, m_msg_valid, input m_msg_ready);
  modport slave  (input m_msg_data, m_msg_core_id, m_msg_valid, output m_msg_ready);
endinterface

// File: rtl/core_msg_fifo.sv
// Per-core synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module core_msg_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/core_msg_arbiter.sv
// Merges per-core message pulses onto one valid/ready port: per-core FIFOs,
// round-robin grant, registered output, sticky overflow flags and a saturating drop count.
module core_msg_arbiter
  import core_msg_pkg::*;
#(
  parameter int CORE_COUNT    = 4,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH    = 4,
  parameter int CORE_ID_WIDTH = core_id_width(CORE_COUNT)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CORE_COUNT*DATA_WIDTH-1:0] core_msg_data,
  input  logic [CORE_COUNT-1:0]            core_msg_valid,
  core_msg_arbiter_if.master               m_msg,
  output logic [CORE_COUNT-1:0]            overflow_flag,
  input  logic [CORE_COUNT-1:0]            overflow_clear,
  output logic [DROP_CNT_W-1:0]            drop_count
);
  logic [CORE_COUNT-1:0]                 full, empty, push, pop, drop;
  logic [CORE_COUNT-1:0][DATA_WIDTH-1:0] head;
  logic [CORE_ID_WIDTH-1:0]              rr_ptr, rr_nxt, gnt_id;
  logic                                  gnt_vld, out_free;
  logic [DROP_CNT_W-1:0]                 drop_cnt, drop_cnt_nxt;
  logic [DROP_CNT_W:0]                   drop_sum;

  assign out_free = !m_msg.m_msg_valid || m_msg.m_msg_ready;

  // Fullness is the registered state; a push to a full FIFO drops even if it pops this cycle.
  for (genvar i = 0; i < CORE_COUNT; i++) begin : g_fifo
    assign push[i] = core_msg_valid[i] & ~full[i];
    assign drop[i] = core_msg_valid[i] &  full[i];
    assign pop[i]  = out_free & gnt_vld & (gnt_id == CORE_ID_WIDTH'(i));

    core_msg_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[i]),
      .push_data (core_msg_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .pop       (pop[i]),
      .head      (head[i]),
      .full      (full[i]),
      .empty     (empty[i])
    );
  end

  // First non-empty FIFO at or after rr_ptr, wrapping modulo CORE_COUNT.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < CORE_COUNT; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= CORE_COUNT) idx = idx - CORE_COUNT;
      if (!gnt_vld && !empty[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = CORE_ID_WIDTH'(idx);
      end
    end
  end

  assign rr_nxt = (gnt_id == CORE_ID_WIDTH'(CORE_COUNT-1)) ? '0 : gnt_id + CORE_ID_WIDTH'(1);

  // One extra bit catches carry out of the 32-bit count so it can saturate.
  always_comb begin
    drop_sum = {1'b0, drop_cnt};
    for (int i = 0; i < CORE_COUNT; i++) drop_sum = drop_sum + (DROP_CNT_W+1)'(drop[i]);
  end

  assign drop_cnt_nxt = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr               <= '0;
      m_msg.m_msg_valid    <= 1'b0;
      m_msg.m_msg_data     <= '0;
      m_msg.m_msg_core_id  <= '0;
      overflow_flag        <= '0;
      drop_cnt             <= '0;
    end else begin
      if (out_free) begin
        m_msg.m_msg_valid <= gnt_vld;
        if (gnt_vld) begin
          m_msg.m_msg_data    <= head[gnt_id];
          m_msg.m_msg_core_id <= gnt_id;
          rr_ptr              <= rr_nxt;
        end
      end
      overflow_flag <= (overflow_flag & ~overflow_clear) | drop;
      drop_cnt      <= drop_cnt_nxt;
    end
  end

  assign drop_count = drop_cnt;
endmodule

// File: tb/tb_core_msg_arbiter.sv
// Directed bench for core_msg_arbiter: reset, latency, round-robin, back-pressure/overflow, clear, saturation.
module tb_core_msg_arbiter;
  localparam int CC = 4;
  localparam int DW = 64;
  localparam int FD = 4;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CC*DW-1:0] core_msg_data = '0;
  logic [CC-1:0]    core_msg_valid = '0;
  logic [CC-1:0]    overflow_flag;
  logic [CC-1:0]    overflow_clear = '0;
  logic [31:0]      drop_count;

  core_msg_arbiter_if #(.DATA_WIDTH(DW), .CORE_ID_WIDTH(IW)) m_if ();

  core_msg_arbiter #(
    .CORE_COUNT (CC),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .core_msg_data  (core_msg_data),
    .core_msg_valid (core_msg_valid),
    .m_msg          (m_if),
    .overflow_flag  (overflow_flag),
    .overflow_clear (overflow_clear),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] got_d[$];
  logic [63:0] got_i[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    core_msg_valid = '0;
    overflow_clear = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_core(input int c, input logic [63:0] v);
    core_msg_data[c*DW +: DW] = v;
  endtask

  // Records every accepted output word until n are seen or the bound expires.
  task automatic collect(input int n, input int bound);
    int cyc;
    cyc = 0;
    got_d.delete();
    got_i.delete();
    while (got_d.size() < n && cyc < bound) begin
      if (m_if.m_msg_valid && m_if.m_msg_ready) begin
        got_d.push_back(m_if.m_msg_data);
        got_i.push_back(64'(m_if.m_msg_core_id));
      end
      tick();
      cyc++;
    end
    chk("collect_count", 64'(got_d.size()), 64'(n));
  endtask

  initial begin
    m_if.m_msg_ready = 1'b1;

    // Reset with all cores pulsing: nothing may leak through.
    rst_n = 1'b0;
    for (int c = 0; c < CC; c++) set_core(c, 64'h5555_0000_0000_0000 | 64'(c));
    core_msg_valid = 4'b1111;
    tick();
    tick();
    rst_n          = 1'b1;
    core_msg_valid = '0;
    chk("rst_valid", 64'(m_if.m_msg_valid), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_flag", 64'(overflow_flag), 64'd0);
    tick(); tick(); tick();
    chk("rst_no_msg", 64'(m_if.m_msg_valid), 64'd0);

    // Single message: visible two cycles after the pulse, gone the next.
    set_core(2, 64'hDEAD_BEEF_0000_0002);
    core_msg_valid = 4'b0100;
    tick();
    core_msg_valid = '0;
    chk("single_t1_valid", 64'(m_if.m_msg_valid), 64'd0);
    tick();
    chk("single_t2_valid", 64'(m_if.m_msg_valid), 64'd1);
    chk("single_data", m_if.m_msg_data, 64'hDEAD_BEEF_0000_0002);
    chk("single_id", 64'(m_if.m_msg_core_id), 64'd2);
    tick();
    chk("single_t3_valid", 64'(m_if.m_msg_valid), 64'd0);

    // Round-robin: 3 simultaneous pulses on all cores.
    do_reset();
    fork
      begin
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < CC; c++) set_core(c, 64'hC0DE_0000_0000_0000 | 64'(c << 8) | 64'(r));
          core_msg_valid = 4'b1111;
          tick();
        end
        core_msg_valid = '0;
      end
      collect(12, 40);
    join
    for (int n = 0; n < 12 && n < got_d.size(); n++) begin
      chk($sformatf("rr_id%0d", n), got_i[n], 64'(n % 4));
      chk($sformatf("rr_data%0d", n), got_d[n],
          64'hC0DE_0000_0000_0000 | 64'((n % 4) << 8) | 64'(n / 4));
    end
    chk("rr_drop", 64'(drop_count), 64'd0);

    // Back-pressure: 7 pulses on core 1 with the sink stalled.
    do_reset();
    m_if.m_msg_ready = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      set_core(1, 64'hB000_0000_0000_0000 | 64'(k));
      core_msg_valid = 4'b0010;
      tick();
    end
    core_msg_valid = '0;
    chk("bp_valid", 64'(m_if.m_msg_valid), 64'd1);
    chk("bp_hold_data", m_if.m_msg_data, 64'hB000_0000_0000_0001);
    chk("bp_hold_id", 64'(m_if.m_msg_core_id), 64'd1);
    chk("bp_drop", 64'(drop_count), 64'd2);
    chk("bp_flag", 64'(overflow_flag), 64'b0010);
    tick(); tick();
    chk("bp_stable_data", m_if.m_msg_data, 64'hB000_0000_0000_0001);
    m_if.m_msg_ready = 1'b1;
    collect(5, 20);
    for (int n = 0; n < 5 && n < got_d.size(); n++) begin
      chk($sformatf("bp_data%0d", n), got_d[n], 64'hB000_0000_0000_0000 | 64'(n + 1));
      chk($sformatf("bp_id%0d", n), got_i[n], 64'd1);
    end
    chk("bp_drained", 64'(m_if.m_msg_valid), 64'd0);

    // Clear alone, refill, then clear colliding with a new drop: set wins.
    overflow_clear = 4'b0010;
    tick();
    overflow_clear = '0;
    chk("clr0_flag", 64'(overflow_flag), 64'd0);
    chk("clr0_drop", 64'(drop_count), 64'd2);
    m_if.m_msg_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_core(1, 64'hA0 + 64'(k));
      core_msg_valid = 4'b0010;
      tick();
    end
    chk("fill_no_drop", 64'(drop_count), 64'd2);
    core_msg_valid = 4'b0010;
    overflow_clear = 4'b0010;
    tick();
    core_msg_valid = '0;
    overflow_clear = '0;
    chk("setwins_flag", 64'(overflow_flag), 64'b0010);
    chk("setwins_drop", 64'(drop_count), 64'd3);
    overflow_clear = 4'b0010;
    tick();
    overflow_clear = '0;
    chk("clr1_flag", 64'(overflow_flag), 64'd0);
    chk("clr1_drop", 64'(drop_count), 64'd3);

    // Multi-core drops and saturation.
    do_reset();
    m_if.m_msg_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      core_msg_valid = 4'b0111;
      tick();
    end
    core_msg_valid = '0;
    chk("multi_drop", 64'(drop_count), 64'd2);
    chk("multi_flag", 64'(overflow_flag), 64'b0110);
    force dut.drop_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.drop_cnt;
    core_msg_valid = 4'b0111;
    tick();
    core_msg_valid = '0;
    chk("sat_drop", 64'(drop_count), 64'hFFFF_FFFF);
    chk("sat_flag", 64'(overflow_flag), 64'b0111);
    core_msg_valid = 4'b0111;
    tick();
    core_msg_valid = '0;
    chk("sat_hold", 64'(drop_count), 64'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/core_msg_arbiter.md
# core_msg_arbiter

Collects the 64-bit `core_msg_data`/`core_msg_valid` message streams from `CORE_COUNT` RISC-V core wrappers and merges them onto one valid/ready message port toward the host/scheduler. Each core wrapper emits single-cycle message pulses with no back-pressure, so the arbiter provides:

- a small per-core FIFO;
- round-robin arbitration across non-empty FIFOs;
- a registered output stage;
- overflow accounting for messages that cannot be absorbed.

## Interface

Parameters:

- `CORE_COUNT`, 4 — number of core message sources, 2..16.
- `DATA_WIDTH`, 64 — message width; equals the core wrapper `core_msg_data` width.
- `FIFO_DEPTH`, 4 — per-core FIFO entries; power of two, ≥ 2.
- `CORE_ID_WIDTH`, `$clog2(CORE_COUNT)` — derived; do not override.

Ports:

- `clk` — input, 1 — sole clock.
- `rst_n` — input, 1 — reset, synchronous, active-low.
- `core_msg_data` — input, `CORE_COUNT*DATA_WIDTH` — core i message in bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `core_msg_valid` — input, `CORE_COUNT` — bit i: one-cycle pulse per message from core i.
- `m_msg_data` — output, `DATA_WIDTH` — granted message.
- `m_msg_core_id` — output, `CORE_ID_WIDTH` — index of the source core.
- `m_msg_valid` — output, 1 — output holds a message.
- `m_msg_ready` — input, 1 — sink accepts when high with `m_msg_valid`.
- `overflow_flag` — output, `CORE_COUNT` — sticky; bit i set when a message from core i was dropped.
- `overflow_clear` — input, `CORE_COUNT` — bit i clears `overflow_flag[i]`.
- `drop_count` — output, 32 — saturating total of dropped messages.

## Operation

Clocking and reset:

- One clock domain; all state changes on the rising edge of `clk`.
- While `rst_n`=0 at an edge:
  - all FIFOs become empty;
  - round-robin pointer becomes 0;
  - `m_msg_valid`, `m_msg_data`, `m_msg_core_id`, `overflow_flag` and `drop_count` become 0.
- Reset mid-operation discards all buffered and in-flight messages, including an output word not yet accepted.

Push (per core i, every cycle):

- If `core_msg_valid[i]`=1 and FIFO i is not full, write the message to FIFO i.
- Fullness uses the registered occupancy at the start of the cycle. A push to a full FIFO is dropped even if that FIFO is popped in the same cycle.
- On a drop:
  - set `overflow_flag[i]`;
  - add 1 to `drop_count`.
- Drops from several cores in one cycle add their count (popcount) to `drop_count`. The count saturates at 0xFFFF_FFFF and never wraps.
- If `overflow_clear[i]` and a new drop on core i occur in the same cycle, set wins.

Output register load:

- The output register loads when it is free: `m_msg_valid`=0, or `m_msg_valid`=1 and `m_msg_ready`=1.
- When free and at least one FIFO is non-empty:
  - grant the first non-empty FIFO at or after the round-robin pointer, wrapping modulo `CORE_COUNT`;
  - pop that FIFO;
  - load `m_msg_data` and `m_msg_core_id`, and set `m_msg_valid`=1;
  - set pointer = grant+1 (mod `CORE_COUNT`).
- When free and all FIFOs are empty: `m_msg_valid` goes to 0 and the pointer is unchanged.

Ordering and handshake:

- Per-core message order is preserved. There is no ordering guarantee across cores.
- While `m_msg_valid`=1 and `m_msg_ready`=0, `m_msg_data` and `m_msg_core_id` hold stable.

## Timing

- Latency: a pulse on `core_msg_valid[i]` in cycle t, with FIFO i and the output stage idle, gives `m_msg_valid`=1 in cycle t+2.
- Throughput: one message per cycle while `m_msg_ready` is held at 1. Back-to-back pops can come from the same or different FIFOs.
- FIFO push and pop in the same cycle on a non-full FIFO: occupancy is unchanged and both operations take effect.
- Push to an empty FIFO and the arbiter sampling that FIFO in the same cycle: not visible to the arbiter. There is no FIFO bypass.
- Fairness: with all FIFOs continuously non-empty and `m_msg_ready`=1, grants cycle 0,1,…,`CORE_COUNT`-1,0,….
- `overflow_flag` and `drop_count` update one edge after the dropping cycle.

## Structure

- Shared package `core_msg_pkg`:
  - default `DATA_WIDTH`;
  - the `CORE_ID_WIDTH` derivation function;
  - the `drop_count` width (32).
- Sub-module `core_msg_fifo`, instantiated `CORE_COUNT` times:
  - synchronous, `FIFO_DEPTH` × `DATA_WIDTH`;
  - pointers with an extra wrap bit;
  - outputs `full`, `empty` and head data.
- Top level contains the round-robin grant logic, the output register, and the overflow/drop counters.

## Test plan

- **Reset:** hold `rst_n`=0 for 2 cycles while driving `core_msg_valid`=4'b1111 → after release, `m_msg_valid`=0, `drop_count`=0, `overflow_flag`=0, and no message emerges.
- **Single message:** core 2 pulses data 0xDEAD_BEEF_0000_0002 at cycle 10 with `m_msg_ready`=1 → `m_msg_valid`=1 at cycle 12 with that data and `m_msg_core_id`=2, then `m_msg_valid`=0 at cycle 13.
- **Round-robin:** all four cores pulse simultaneously, 3 times each, with `m_msg_ready`=1 → 12 outputs with ids 0,1,2,3,0,1,2,3,0,1,2,3, and per-core data in push order.
- **Back-pressure and overflow:** `m_msg_ready`=0; core 1 pulses 7 messages in consecutive cycles (`FIFO_DEPTH`=4) →
  - the output register holds message 1;
  - FIFO holds messages 2–5;
  - messages 6–7 are dropped: `drop_count`=2, `overflow_flag`=4'b0010;
  - after raising `m_msg_ready`, messages 1–5 emerge in order and stable.
- **Clear vs set:** assert `overflow_clear[1]` in the same cycle as a new drop on core 1 → flag stays 1. Clear alone the next cycle → flag becomes 0 and `drop_count` is unchanged.
- **Saturation:** force `drop_count` to 0xFFFF_FFFE, then cause 3 simultaneous drops → `drop_count`=0xFFFF_FFFF.
